stopwatch_ctrl: RTL and testbench

//  Run/pause/clear sequencer for the stopwatch seconds/minutes time units.
//  - Edge-detects the user controls and runs a 4-state FSM.
//  - Prescales m_clk into the 1-per-second tick_en that drives the seconds unit's pulse_en.
//  - Issues a synchronous clear pulse to all time units.
//  - Sits between the debounced button inputs and the time-unit counter chain.

---
 rtl/stopwatch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Run/pause/clear sequencer for the stopwatch seconds/minutes time units.
//   Edge-detects the user buttons, runs a 4-state FSM (IDLE/RUN/PAUSE/HALT),
//   prescales m_clk into a 1-per-second tick_en and issues a synchronous
//   clear pulse to the whole counter chain.
//
// Parameters
//   TICK_DIV     m_clk cycles per tick_en pulse (>= 2)
//   HALT_AT_MAX  1: freeze at 59:59 in HALT; 0: let the counters wrap to 00:00
//
// Ports
//   m_clk      in   system clock, rising edge
//   a_rst_n    in   asynchronous active-low reset
//   start_in   in   start/resume request (level, rising edge acts)
//   stop_in    in   pause request (level, rising edge acts)
//   clear_in   in   clear request (level, rising edge acts)
//   sec_val    in   [5:0] current seconds count
//   min_val    in   [5:0] current minutes count
//   tick_en    out  1-cycle count pulse to the seconds unit
//   units_clr  out  1-cycle synchronous clear to all time units
//   state_o    out  [1:0] FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 HALT
//   running    out  high while state_o == RUN
//
// Optional build macro LAP_CAPTURE_EN adds lap capture:
//   lap_in     in   lap request (level, rising edge acts in RUN or HALT)
//   lap_sec    out  [5:0] captured seconds
//   lap_min    out  [5:0] captured minutes
//   lap_valid  out  a lap has been captured since the last clear
`timescale 1ns/1ps

module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV    = 100_000_000,
   parameter int unsigned HALT_AT_MAX = 1
) (
   input  logic       m_clk,
   input  logic       a_rst_n,
   input  logic       start_in,
   input  logic       stop_in,
   input  logic       clear_in,
   input  logic [5:0] sec_val,
   input  logic [5:0] min_val,
`ifdef LAP_CAPTURE_EN
   input  logic       lap_in,
   output logic [5:0] lap_sec,
   output logic [5:0] lap_min,
   output logic       lap_valid,
`endif
   output logic       tick_en,
   output logic       units_clr,
   output logic [1:0] state_o,
   output logic       running
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10,
      StHalt  = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q;
   logic          start_hist_q, stop_hist_q, clear_hist_q;

   logic start_edge, stop_edge, clear_edge;
   logic clr_ev, stop_ev, start_ev;
   logic presc_en, tick_pt, at_max, halt_now;

   assign start_edge = start_in & ~start_hist_q;
   assign stop_edge  = stop_in & ~stop_hist_q;
   assign clear_edge = clear_in & ~clear_hist_q;

   // Priority clear > stop > start; losing edges in the same cycle are dropped.
   assign clr_ev   = clear_edge;
   assign stop_ev  = stop_edge & ~clear_edge;
   assign start_ev = start_edge & ~stop_edge & ~clear_edge;

   assign presc_en = (state_q == StRun) & ~stop_ev & ~clr_ev;
   assign tick_pt  = presc_en & (presc_q == PRESC_MAX);
   assign at_max   = tick_pt & (sec_val == 6'd59) & (min_val == 6'd59);
   assign halt_now = at_max & (HALT_AT_MAX != 0);

   always_comb begin
      state_d = state_q;
      if (clr_ev) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (start_ev) state_d = StRun;
            StRun: begin
               if (stop_ev)       state_d = StPause;
               else if (halt_now) state_d = StHalt;
            end
            StPause: if (start_ev) state_d = StRun;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
         endcase
      end
   end

`ifdef LAP_CAPTURE_EN
   logic lap_hist_q;
   logic lap_edge;
   assign lap_edge = lap_in & ~lap_hist_q;
`endif

   always_ff @(posedge m_clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state_q      <= StIdle;
         presc_q      <= '0;
         start_hist_q <= 1'b0;
         stop_hist_q  <= 1'b0;
         clear_hist_q <= 1'b0;
         tick_en      <= 1'b0;
         units_clr    <= 1'b0;
         running      <= 1'b0;
`ifdef LAP_CAPTURE_EN
         lap_hist_q   <= 1'b0;
         lap_sec      <= '0;
         lap_min      <= '0;
         lap_valid    <= 1'b0;
`endif
      end else begin
         start_hist_q <= start_in;
         stop_hist_q  <= stop_in;
         clear_hist_q <= clear_in;

         state_q   <= state_d;
         running   <= (state_d == StRun);
         units_clr <= clr_ev;
         // Reaching 59:59 in halt mode swallows the tick so the counters hold.
         tick_en   <= tick_pt & ~halt_now;

         // A stop edge holds presc, so a resume finishes the partial second.
         if (clr_ev || halt_now) begin
            presc_q <= '0;
         end else if (presc_en) begin
            presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
         end

`ifdef LAP_CAPTURE_EN
         lap_hist_q <= lap_in;
         if (clr_ev) begin
            lap_sec   <= '0;
            lap_min   <= '0;
            lap_valid <= 1'b0;
         end else if (lap_edge && (state_q == StRun || state_q == StHalt)) begin
            // sec_val/min_val still hold pre-tick values this cycle.
            lap_sec   <= sec_val;
            lap_min   <= min_val;
            lap_valid <= 1'b1;
         end
`endif
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4. Two instances share the stimulus:
// index 0 is built with HALT_AT_MAX=1, index 1 with HALT_AT_MAX=0.
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

   localparam int DIV = 4;

   logic       m_clk = 1'b0;
   logic       a_rst_n = 1'b0;
   logic       start_in = 1'b0, stop_in = 1'b0, clear_in = 1'b0;
   logic [5:0] sec_val = '0, min_val = '0;

   logic       tk_h, cl_h, rn_h, tk_w, cl_w, rn_w;
   logic [1:0] st_h, st_w;
`ifdef LAP_CAPTURE_EN
   logic       lap_in = 1'b0;
   logic [5:0] lsec_h, lmin_h, lsec_w, lmin_w;
   logic       lval_h, lval_w;
`endif

   stopwatch_ctrl #(.TICK_DIV(DIV), .HALT_AT_MAX(1)) u_halt (
      .m_clk(m_clk), .a_rst_n(a_rst_n), .start_in(start_in), .stop_in(stop_in),
      .clear_in(clear_in), .sec_val(sec_val), .min_val(min_val),
`ifdef LAP_CAPTURE_EN
      .lap_in(lap_in), .lap_sec(lsec_h), .lap_min(lmin_h), .lap_valid(lval_h),
`endif
      .tick_en(tk_h), .units_clr(cl_h), .state_o(st_h), .running(rn_h)
   );

   stopwatch_ctrl #(.TICK_DIV(DIV), .HALT_AT_MAX(0)) u_wrap (
      .m_clk(m_clk), .a_rst_n(a_rst_n), .start_in(start_in), .stop_in(stop_in),
      .clear_in(clear_in), .sec_val(sec_val), .min_val(min_val),
`ifdef LAP_CAPTURE_EN
      .lap_in(lap_in), .lap_sec(lsec_w), .lap_min(lmin_w), .lap_valid(lval_w),
`endif
      .tick_en(tk_w), .units_clr(cl_w), .state_o(st_w), .running(rn_w)
   );

   always #5 m_clk = ~m_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode: 0 idle, 1 run, 2 pause, 3 halt. elapsed counts RUN cycles that
   // advanced time since the last clear/halt; a second completes on every
   // cycle that brings the count to a multiple of DIV.
   int   m_state   [2];
   int   m_elapsed [2];
   bit   m_tick    [2];
   bit   m_clr     [2];
   logic m_ps, m_pp, m_pc;
   logic ev_clr, ev_stop, ev_start;

   assign ev_clr   = clear_in & ~m_pc;
   assign ev_stop  = stop_in & ~m_pp & ~ev_clr;
   assign ev_start = start_in & ~m_ps & ~(stop_in & ~m_pp) & ~ev_clr;

   function automatic bit m_second_done(int h);
      return m_state[h] == 1 && !ev_stop && !ev_clr && ((m_elapsed[h] + 1) % DIV == 0);
   endfunction

   function automatic bit m_halts(int h);
      return h == 0 && m_second_done(h) && sec_val == 6'd59 && min_val == 6'd59;
   endfunction

   function automatic int m_next_state(int h);
      if (ev_clr) return 0;
      if (m_state[h] == 0 || m_state[h] == 2) return ev_start ? 1 : m_state[h];
      if (m_state[h] == 1) begin
         if (ev_stop) return 2;
         return m_halts(h) ? 3 : 1;
      end
      return 3;
   endfunction

   always @(posedge m_clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         m_ps <= 1'b0;
         m_pp <= 1'b0;
         m_pc <= 1'b0;
         for (int h = 0; h < 2; h++) begin
            m_state[h]   <= 0;
            m_elapsed[h] <= 0;
            m_tick[h]    <= 1'b0;
            m_clr[h]     <= 1'b0;
         end
      end else begin
         m_ps <= start_in;
         m_pp <= stop_in;
         m_pc <= clear_in;
         for (int h = 0; h < 2; h++) begin
            m_tick[h]  <= m_second_done(h) && !m_halts(h);
            m_clr[h]   <= ev_clr;
            m_state[h] <= m_next_state(h);
            if (ev_clr || m_halts(h))
               m_elapsed[h] <= 0;
            else if (m_state[h] == 1 && !ev_stop)
               m_elapsed[h] <= m_elapsed[h] + 1;
         end
      end
   end

   // Compare process: every falling edge, both instances against the model.
   always @(negedge m_clk) begin
      check("halt.state_o",   st_h, m_state[0]);
      check("halt.tick_en",   tk_h, m_tick[0]);
      check("halt.units_clr", cl_h, m_clr[0]);
      check("halt.running",   rn_h, m_state[0] == 1);
      check("wrap.state_o",   st_w, m_state[1]);
      check("wrap.tick_en",   tk_w, m_tick[1]);
      check("wrap.units_clr", cl_w, m_clr[1]);
      check("wrap.running",   rn_w, m_state[1] == 1);
   end

   // Advance n rising edges, then settle 2ns past the edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge m_clk);
         #2;
      end
   endtask

   // ---------------- directed stimulus + literal expectations ----------------
   initial begin
      cyc(2);
      a_rst_n = 1'b1;
      check("reset state", st_h, 0);
      check("reset tick", tk_h, 0);
      check("reset clr", cl_h, 0);
      check("reset running", rn_h, 0);

      start_in = 1'b1; cyc(1); start_in = 1'b0;
      check("start->RUN", st_h, 1);
      check("start running", rn_h, 1);
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         check("tick cadence", tk_h, (i % 4 == 0) ? 1 : 0);
      end

      // Pause two cycles into a second.
      cyc(2);
      stop_in = 1'b1; cyc(1); stop_in = 1'b0;
      check("stop->PAUSE", st_h, 2);
      check("pause running", rn_h, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check("no tick paused", tk_h, 0);
      end
      start_in = 1'b1; cyc(1); start_in = 1'b0;
      check("resume->RUN", st_h, 1);
      cyc(1); check("resume +1", tk_h, 0);
      cyc(1); check("resume tick", tk_h, 1);

      // Stop exactly at the tick point: tick suppressed, fires after resume.
      cyc(3);
      check("pre-stop tick", tk_h, 0);
      stop_in = 1'b1; cyc(1); stop_in = 1'b0;
      check("stop at max state", st_h, 2);
      check("stop at max tick", tk_h, 0);
      cyc(3);
      start_in = 1'b1; cyc(1); start_in = 1'b0;
      check("resume2 state", st_h, 1);
      check("resume2 no tick yet", tk_h, 0);
      cyc(1); check("held tick after resume", tk_h, 1);

      // All three buttons together in RUN: clear wins.
      cyc(1);
      start_in = 1'b1; stop_in = 1'b1; clear_in = 1'b1; cyc(1);
      start_in = 1'b0; stop_in = 1'b0; clear_in = 1'b0;
      check("triple->IDLE", st_h, 0);
      check("triple clr", cl_h, 1);
      check("triple tick", tk_h, 0);
      cyc(1); check("clr is 1 cycle", cl_h, 0);
      clear_in = 1'b1; cyc(1); clear_in = 1'b0;
      check("clear in IDLE", cl_h, 1);

      // Max reached at the tick point.
      start_in = 1'b1; cyc(1); start_in = 1'b0;
      sec_val = 6'd59; min_val = 6'd59;
      cyc(3); check("max pre tick", tk_h, 0);
      cyc(1);
      check("halt no tick", tk_h, 0);
      check("halt state", st_h, 3);
      check("wrap tick", tk_w, 1);
      check("wrap state", st_w, 1);
      sec_val = 6'd0; min_val = 6'd0;
      start_in = 1'b1; cyc(1); start_in = 1'b0;
      check("halt ignores start", st_h, 3);
      stop_in = 1'b1; cyc(1); stop_in = 1'b0;
      check("halt ignores stop", st_h, 3);
      check("wrap stop->PAUSE", st_w, 2);
      clear_in = 1'b1; cyc(1); clear_in = 1'b0;
      check("halt clear->IDLE", st_h, 0);
      check("halt clear pulse", cl_h, 1);

      // Reset mid-RUN with presc at its last count.
      start_in = 1'b1; cyc(1); start_in = 1'b0;
      cyc(3);
      a_rst_n = 1'b0;
      #1;
      check("async reset state", st_h, 0);
      check("async reset tick", tk_h, 0);
      check("async reset running", rn_h, 0);
      cyc(1);
      a_rst_n = 1'b1;
      start_in = 1'b1; cyc(1); start_in = 1'b0;
      check("post-reset RUN", st_h, 1);
      for (int i = 1; i <= 4; i++) begin
         cyc(1);
         check("post-reset tick", tk_h, (i == 4) ? 1 : 0);
      end

`ifdef LAP_CAPTURE_EN
      sec_val = 6'd17; min_val = 6'd2;
      lap_in = 1'b1; cyc(1); lap_in = 1'b0;
      check("lap_sec", lsec_h, 17);
      check("lap_min", lmin_h, 2);
      check("lap_valid", lval_h, 1);
      clear_in = 1'b1; cyc(1); clear_in = 1'b0;
      check("lap_sec clr", lsec_h, 0);
      check("lap_min clr", lmin_h, 0);
      check("lap_valid clr", lval_h, 0);
`endif

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
